washing_machine_timer: RTL and testbench

WASHING_MACHINE_TIMER -- requirements
Module: washing_machine_timer

---
 rtl/washing_machine_timer.sv | 138 +++++++++++++
 tb/tb_washing_machine_timer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/washing_machine_timer.sv
// Phase timer for a washing-machine controller: counts each decoded phase and raises a per-phase done flag.
// Latency: done flag rises DUR edges after the (re)start edge. No backpressure; WM_TIMER_DOOR_PAUSE_EN adds spin door-pause.
module washing_machine_timer #(
    parameter int unsigned FILL_CYCLES  = 16,
    parameter int unsigned WASH_CYCLES  = 32,
    parameter int unsigned RINSE_CYCLES = 24,
    parameter int unsigned DRAIN_CYCLES = 12,
    parameter int unsigned SPIN_CYCLES  = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic agitator,
    input  logic motor,
    input  logic pump,
    input  logic speed,
    input  logic water_fill,
    input  logic door,
    output logic tfill,
    output logic twash,
    output logic trinse,
    output logic tdrain,
    output logic tspin,
    output logic busy,
    output logic phase_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_SPIN  = 3'd4
    } phase_t;

    state_t      state;
    phase_t      phase;
    phase_t      dec_phase;
    logic [15:0] count;
    logic [15:0] dur_m1;
    logic [1:0]  wash_cnt;
    logic        err_now;
    logic        relaunch;
    logic        door_hold;
    logic        rinse_pass;

    always_comb begin
        dec_phase = PH_NONE;
        if (water_fill)            dec_phase = PH_FILL;
        else if (pump)             dec_phase = PH_DRAIN;
        else if (motor && speed)   dec_phase = PH_SPIN;
        else if (agitator && motor) dec_phase = PH_WASH;
    end

    assign err_now = (({1'b0, water_fill} + {1'b0, pump} + {1'b0, agitator & motor}) > 2'd1)
                   || (speed && !motor);

    // The second wash of a cycle is the rinse pass and runs on the rinse duration.
    assign rinse_pass = (wash_cnt == 2'd2);

    always_comb begin
        dur_m1 = 16'd0;
        case (phase)
            PH_FILL:  dur_m1 = 16'(FILL_CYCLES - 1);
            PH_WASH:  dur_m1 = rinse_pass ? 16'(RINSE_CYCLES - 1) : 16'(WASH_CYCLES - 1);
            PH_DRAIN: dur_m1 = 16'(DRAIN_CYCLES - 1);
            PH_SPIN:  dur_m1 = 16'(SPIN_CYCLES - 1);
            default:  dur_m1 = 16'd0;
        endcase
    end

    // A new non-idle phase while running, or any change once done, restarts like an explicit restart.
    assign relaunch = restart
                   || ((state == DONE) && (dec_phase != phase))
                   || ((state == RUN) && (dec_phase != phase) && (dec_phase != PH_NONE));

`ifdef WM_TIMER_DOOR_PAUSE_EN
    assign door_hold = (state == RUN) && (phase == PH_SPIN) && door;
`else
    logic unused_door;
    assign unused_door = door;
    assign door_hold   = 1'b0;
`endif

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= PH_NONE;
            count     <= '0;
            wash_cnt  <= '0;
            tfill     <= 1'b0;
            twash     <= 1'b0;
            trinse    <= 1'b0;
            tdrain    <= 1'b0;
            tspin     <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            phase_err <= err_now || (phase_err && !restart);
            if (relaunch) begin
                state  <= (dec_phase == PH_NONE) ? IDLE : RUN;
                phase  <= dec_phase;
                count  <= '0;
                tfill  <= 1'b0;
                twash  <= 1'b0;
                trinse <= 1'b0;
                tdrain <= 1'b0;
                tspin  <= 1'b0;
                if ((dec_phase == PH_WASH) && (wash_cnt != 2'd2))
                    wash_cnt <= wash_cnt + 2'd1;
            end else if ((state == RUN) && !door_hold) begin
                if (dec_phase == PH_NONE) begin
                    state <= IDLE;
                end else if (count == dur_m1) begin
                    state <= DONE;
                    case (phase)
                        PH_FILL:  tfill <= 1'b1;
                        PH_WASH: begin
                            twash  <= 1'b1;
                            trinse <= rinse_pass;
                        end
                        PH_DRAIN: tdrain <= 1'b1;
                        PH_SPIN: begin
                            tspin    <= 1'b1;
                            wash_cnt <= '0;
                        end
                        default: ;
                    endcase
                end else begin
                    count <= count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_washing_machine_timer.sv
// Bench for washing_machine_timer: directed phase scenarios plus randomized controller traffic vs a countdown model.
module tb_washing_machine_timer;

    localparam int FILL_C  = 16;
    localparam int WASH_C  = 32;
    localparam int RINSE_C = 24;
    localparam int DRAIN_C = 12;
    localparam int SPIN_C  = 40;

    localparam int M_NONE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_WASH  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_SPIN  = 4;

    logic clk = 1'b0;
    logic rst_n, restart, agitator, motor, pump, speed, water_fill, door;
    logic tfill, twash, trinse, tdrain, tspin, busy, phase_err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 timing, 2 finished; m_left counts edges still to go.
    int m_mode, m_ph, m_left, m_washes;
    bit m_fill, m_wash, m_rinse, m_drain, m_spin, m_err;

    always #5 clk = ~clk;

    washing_machine_timer #(
        .FILL_CYCLES (FILL_C),
        .WASH_CYCLES (WASH_C),
        .RINSE_CYCLES(RINSE_C),
        .DRAIN_CYCLES(DRAIN_C),
        .SPIN_CYCLES (SPIN_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .agitator  (agitator),
        .motor     (motor),
        .pump      (pump),
        .speed     (speed),
        .water_fill(water_fill),
        .door      (door),
        .tfill     (tfill),
        .twash     (twash),
        .trinse    (trinse),
        .tdrain    (tdrain),
        .tspin     (tspin),
        .busy      (busy),
        .phase_err (phase_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %07b expected %07b at %0t", tag, obs[6:0], exp[6:0], $time);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {tfill, twash, trinse, tdrain, tspin, busy, phase_err};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_fill, m_wash, m_rinse, m_drain, m_spin, (m_mode == 1), m_err};
    endfunction

    function automatic int decode_phase();
        if (water_fill)         return M_FILL;
        if (pump)               return M_DRAIN;
        if (motor && speed)     return M_SPIN;
        if (agitator && motor)  return M_WASH;
        return M_NONE;
    endfunction

    function automatic int dur_of(input int ph, input int washes);
        case (ph)
            M_FILL:  return FILL_C;
            M_WASH:  return (washes >= 2) ? RINSE_C : WASH_C;
            M_DRAIN: return DRAIN_C;
            M_SPIN:  return SPIN_C;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int d;
        bit bad, hold, relaunch;
        if (!rst_n) begin
            m_mode = 0; m_ph = M_NONE; m_left = 0; m_washes = 0;
            {m_fill, m_wash, m_rinse, m_drain, m_spin, m_err} = '0;
            return;
        end
        d    = decode_phase();
        bad  = ((int'(water_fill) + int'(pump) + int'(agitator && motor)) > 1) || (speed && !motor);
        hold = 1'b0;
`ifdef WM_TIMER_DOOR_PAUSE_EN
        hold = (m_mode == 1) && (m_ph == M_SPIN) && door;
`endif
        relaunch = restart || ((m_mode == 2) && (d != m_ph))
                || ((m_mode == 1) && (d != m_ph) && (d != M_NONE));
        m_err = bad || (m_err && !restart);
        if (relaunch) begin
            {m_fill, m_wash, m_rinse, m_drain, m_spin} = '0;
            m_ph   = d;
            m_mode = (d == M_NONE) ? 0 : 1;
            if (d == M_WASH && m_washes < 2) m_washes++;
            m_left = dur_of(d, m_washes);
        end else if (m_mode == 1 && !hold) begin
            if (d == M_NONE) begin
                m_mode = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    case (m_ph)
                        M_FILL:  m_fill = 1'b1;
                        M_WASH: begin m_wash = 1'b1; m_rinse = (m_washes >= 2); end
                        M_DRAIN: m_drain = 1'b1;
                        M_SPIN: begin m_spin = 1'b1; m_washes = 0; end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_val(tag, 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic cyc(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic set_in(input int ph);
        {water_fill, pump, motor, speed, agitator} = '0;
        case (ph)
            M_FILL:  water_fill = 1'b1;
            M_WASH: begin agitator = 1'b1; motor = 1'b1; end
            M_DRAIN: pump = 1'b1;
            M_SPIN: begin motor = 1'b1; speed = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic launch(input int ph, input string tag);
        set_in(ph);
        restart = 1'b1;
        step(tag);
        restart = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; door = 1'b0;
        set_in(M_NONE);
        cyc(2, "reset");
        check_val("reset_outs", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;

        // Fill: flag after edge 16, not before.
        launch(M_FILL, "fill_start");
        cyc(15, "fill_run");
        check_val("fill_edge15", 32'(dut_vec()), 32'(7'b0000010));
        step("fill_end");
        check_val("fill_done", 32'(dut_vec()), 32'(7'b1000000));

        // Wash then rinse pass.
        launch(M_WASH, "wash1_start");
        cyc(31, "wash1_run");
        check_val("wash1_edge31", 32'(dut_vec()), 32'(7'b0000010));
        step("wash1_end");
        check_val("wash1_done", 32'(dut_vec()), 32'(7'b0100000));
        launch(M_WASH, "wash2_start");
        cyc(23, "wash2_run");
        check_val("wash2_edge23", 32'(dut_vec()), 32'(7'b0000010));
        step("wash2_end");
        check_val("wash2_done", 32'(dut_vec()), 32'(7'b0110000));

        // Spin with the door opened for 10 edges mid-count.
        launch(M_SPIN, "spin_start");
        cyc(20, "spin_run");
        set_in(M_NONE); door = 1'b1;
        cyc(10, "spin_door");
        set_in(M_SPIN); door = 1'b0;
        cyc(19, "spin_resume");
`ifdef WM_TIMER_DOOR_PAUSE_EN
        check_val("spin_edge49", 32'(dut_vec()), 32'(7'b0000010));
        step("spin_end");
        check_val("spin_done", 32'(dut_vec()), 32'(7'b0000100));
`else
        check_val("spin_edge49", 32'(dut_vec()), 32'(7'b0000000));
        step("spin_end");
        check_val("spin_idle", 32'(dut_vec()), 32'(7'b0000000));
`endif

        // Reset in the middle of a drain.
        launch(M_DRAIN, "drain_start");
        cyc(7, "drain_run");
        rst_n = 1'b0;
        step("drain_reset");
        check_val("drain_reset_outs", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        cyc(15, "drain_after");
        check_val("drain_never", 32'(dut_vec()), 32'h0);

        // Illegal combination, then cleared by restart.
        set_in(M_NONE); water_fill = 1'b1; pump = 1'b1;
        step("err_set");
        check_val("err_set_outs", 32'(dut_vec()), 32'(7'b0000001));
        set_in(M_NONE); restart = 1'b1;
        step("err_clr");
        check_val("err_clr_outs", 32'(dut_vec()), 32'h0);
        restart = 1'b0;

        // Restart coincident with the final count.
        launch(M_FILL, "coin_start");
        cyc(15, "coin_run");
        restart = 1'b1;
        step("coin_restart");
        check_val("coin_no_flag", 32'(dut_vec()), 32'(7'b0000010));
        restart = 1'b0;
        cyc(15, "coin_rerun");
        check_val("coin_edge15", 32'(dut_vec()), 32'(7'b0000010));
        step("coin_end");
        check_val("coin_done", 32'(dut_vec()), 32'(7'b1000000));

        // Randomized controller programs with occasional noise and resets.
        for (int p = 0; p < 120; p++) begin
            int ph, len;
            ph  = int'($urandom_range(0, 4));
            len = int'($urandom_range(1, 60));
            set_in(ph);
            door    = 1'b0;
            restart = ($urandom_range(0, 3) != 0);
            step("rand_start");
            restart = 1'b0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 19) == 0) begin
                    water_fill = 1'($urandom_range(0, 1));
                    pump       = 1'($urandom_range(0, 1));
                    motor      = 1'($urandom_range(0, 1));
                    speed      = 1'($urandom_range(0, 1));
                    agitator   = 1'($urandom_range(0, 1));
                    restart    = 1'($urandom_range(0, 1));
                    door       = 1'($urandom_range(0, 1));
                end else begin
                    set_in(ph);
                    restart = 1'b0;
                    door    = ($urandom_range(0, 7) == 0);
                end
                rst_n = ($urandom_range(0, 199) != 0);
                step("rand");
            end
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
